// File: rtl/cbus_ram_responder_pkg.sv
// -----------------------------------------------------------------------------
// cbus_ram_responder_pkg
//
// Shared types for the simplified burst cache bus (cbus): request/response
// structs, burst and responder-state enums, and the beat-address helper used
// by responders, initiators and checkers alike.
//
// cbus_req_t  (151 bits): valid, addr[63:0], size[2:0], len[7:0],
//                         burst[1:0], is_write, data[63:0], strobe[7:0]
// cbus_resp_t (66 bits) : ready, last, data[63:0]
//
// len is encoded as (beats - 1); size is log2(bytes per beat).
// -----------------------------------------------------------------------------
package cbus_ram_responder_pkg;

    localparam int CBUS_DATA_W = 64;
    localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

    typedef logic [63:0]            addr_t;
    typedef logic [2:0]             msize_t;
    typedef logic [7:0]             mlen_t;
    typedef logic [7:0]             u8;
    typedef logic [CBUS_DATA_W-1:0] cbus_data_t;
    typedef logic [CBUS_STRB_W-1:0] cbus_strb_t;

    typedef enum logic [1:0] {
        BURST_FIXED    = 2'd0,
        BURST_INCR     = 2'd1,
        BURST_WRAP     = 2'd2,
        BURST_RESERVED = 2'd3
    } axi_burst_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        TURN  = 2'd3
    } cbus_rsp_state_t;

    typedef struct packed {
        logic            valid;
        addr_t           addr;
        msize_t          size;
        mlen_t           len;
        axi_burst_type_t burst;
        logic            is_write;
        cbus_data_t      data;
        cbus_strb_t      strobe;
    } cbus_req_t;

    typedef struct packed {
        logic       ready;
        logic       last;
        cbus_data_t data;
    } cbus_resp_t;

    // Byte address of beat number 'beat' of a burst. All arithmetic is 64-bit
    // modular. RESERVED bursts are treated as INCR. The WRAP form assumes the
    // initiator issues power-of-two burst lengths, as the bus requires.
    function automatic addr_t cbus_beat_addr(
        input addr_t           start,
        input msize_t          size,
        input mlen_t           len,
        input axi_burst_type_t burst,
        input u8               beat
    );
        addr_t offset;
        addr_t bound;
        offset = addr_t'(beat) << size;
        bound  = (addr_t'(len) + addr_t'(1)) << size;
        case (burst)
            BURST_FIXED: cbus_beat_addr = start;
            BURST_WRAP:  cbus_beat_addr = (start & ~(bound - addr_t'(1)))
                                        | ((start + offset) & (bound - addr_t'(1)));
            default:     cbus_beat_addr = start + offset;
        endcase
    endfunction

endpackage

// File: rtl/cbus_stall_lfsr.sv
// -----------------------------------------------------------------------------
// cbus_stall_lfsr
//
// Pseudo-random stall generator for the RAM responder. A 16-bit Fibonacci
// LFSR (taps 16,14,13,11) seeded with 16'hACE1 on reset advances every cycle;
// a stall is requested whenever its two low bits are both zero (~1 in 4).
// Only instantiated when CBUS_RESPONDER_RANDOM_STALL_EN is defined.
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset (reloads the seed)
//   stall  out  1 = hold off the current beat this cycle
// -----------------------------------------------------------------------------
module cbus_stall_lfsr (
    input  logic clk,
    input  logic reset,
    output logic stall
);

    localparam logic [15:0] SEED = 16'hACE1;

    logic [15:0] lfsr;
    logic        feedback;

    // Tap positions 16,14,13,11 map to bit indices 15,13,12,10.
    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);

endmodule

// File: rtl/cbus_ram_responder.sv
// -----------------------------------------------------------------------------
// cbus_ram_responder
//
// Responder end of the simplified burst cache bus, backed by a 64-bit-wide
// on-chip RAM. Serves FIXED / INCR / WRAP read and write bursts with a
// programmable number of idle cycles before the first beat.
//
// Parameters:
//   MEM_WORDS      RAM depth in 64-bit words (power of two, >= 2)
//   BASE_ADDR      byte address mapped to RAM word 0
//   FIRST_LATENCY  idle cycles between request acceptance and first beat (0..15)
//
// Ports:
//   clk    in   clock
//   reset  in   synchronous, active-high reset (control only; RAM keeps data)
//   creq   in   packed cbus_req_t from the initiator
//   cresp  out  packed cbus_resp_t (ready / last / data), combinational
//
// Build option:
//   CBUS_RESPONDER_RANDOM_STALL_EN  inserts pseudo-random single-cycle stalls
//                                   during the data phase.
// -----------------------------------------------------------------------------
module cbus_ram_responder
    import cbus_ram_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS     = 4096,
    parameter logic [63:0] BASE_ADDR     = 64'h0000_0000_8000_0000,
    parameter int unsigned FIRST_LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$bits(cbus_req_t)-1:0]  creq,
    output logic [$bits(cbus_resp_t)-1:0] cresp
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0]  LAT   = 4'(FIRST_LATENCY);

    cbus_req_t       req;
    cbus_resp_t      resp;

    cbus_rsp_state_t state;
    logic [3:0]      cnt;
    u8               beat;

    // Burst descriptor captured at acceptance; initiator data/strobe are
    // used live since they change per beat.
    addr_t           start_addr;
    msize_t          size_q;
    mlen_t           len_q;
    axi_burst_type_t burst_q;
    logic            is_write_q;

    addr_t           beat_addr;
    addr_t           rel_addr;
    logic            in_range;
    logic [IDX_W-1:0] word_idx;
    logic            stall;
    logic            beat_fire;
    logic            last_beat;

    cbus_data_t      mem [MEM_WORDS];

    assign req   = creq;
    assign cresp = resp;

`ifdef CBUS_RESPONDER_RANDOM_STALL_EN
    cbus_stall_lfsr u_stall_lfsr (
        .clk   (clk),
        .reset (reset),
        .stall (stall)
    );
`else
    assign stall = 1'b0;
`endif

    // Address decode. rel_addr wraps modulo 2^64, so an address below the
    // base must be rejected explicitly rather than by the index bound alone.
    assign beat_addr = cbus_beat_addr(start_addr, size_q, len_q, burst_q, beat);
    assign rel_addr  = beat_addr - BASE_ADDR;
    assign in_range  = (beat_addr >= BASE_ADDR)
                    && ((rel_addr >> 3) < addr_t'(MEM_WORDS));
    assign word_idx  = rel_addr[IDX_W+2:3];

    assign beat_fire = (state == BURST) && !stall;
    assign last_beat = (beat == len_q);

    // Response is a pure function of state and RAM: everything is zero
    // outside an active beat, and read data is zero for writes and for
    // out-of-range beats.
    always_comb begin
        resp = '0;
        if (beat_fire) begin
            resp.ready = 1'b1;
            resp.last  = last_beat;
            if (!is_write_q && in_range) begin
                resp.data = mem[word_idx];
            end
        end
    end

    // Control FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            beat  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req.valid) begin
                        beat <= '0;
                        if (LAT == 4'd0) begin
                            state <= BURST;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT;
                        end
                    end
                end
                // Leave on the edge that brings cnt to zero, so exactly
                // FIRST_LATENCY cycles are spent here.
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (beat_fire) begin
                        beat <= beat + 8'd1;
                        if (last_beat) begin
                            state <= TURN;
                        end
                    end
                end
                TURN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Burst descriptor capture (data path, not reset).
    always_ff @(posedge clk) begin
        if (state == IDLE && req.valid) begin
            start_addr <= req.addr;
            size_q     <= req.size;
            len_q      <= req.len;
            burst_q    <= req.burst;
            is_write_q <= req.is_write;
        end
    end

    // RAM write port. Narrow sizes still address the whole aligned word;
    // only the strobe selects bytes. A beat coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && beat_fire && is_write_q && in_range) begin
            for (int i = 0; i < CBUS_STRB_W; i++) begin
                if (req.strobe[i]) begin
                    mem[word_idx][8*i +: 8] <= req.data[8*i +: 8];
                end
            end
        end
    end

endmodule
